decode_ctrl_pipe: RTL and testbench



---
 rtl/decode_ctrl_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// RV32I main decoder with a registered, valid/ready output stage toward EX.
// Inserts one bubble on load-use and holds off issue for a fixed time after a SYSTEM op.
module decode_ctrl_pipe #(
  parameter int OPCODEWIDTH        = 7,
  parameter int FUN3WIDTH          = 3,
  parameter int REGADDRWIDTH       = 5,
  parameter int WORDTYPEWIDTH      = 4,
  parameter int REGWRITENFROMWIDTH = 3,
  parameter int CSR_STALL_CYCLES   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          id_valid,
  output logic                          id_ready,
  input  logic [OPCODEWIDTH-1:0]        id_op,
  input  logic [FUN3WIDTH-1:0]          id_fun3,
  input  logic [REGADDRWIDTH-1:0]       id_rd,
  input  logic [REGADDRWIDTH-1:0]       id_rs1,
  input  logic [REGADDRWIDTH-1:0]       id_rs2,
  input  logic                          ex_ready,
  output logic                          ex_valid,
  output logic [REGADDRWIDTH-1:0]       ex_rd,
  output logic                          ex_illegal,
  output logic                          ex_rf_read,
  output logic                          ex_rf_write,
  output logic                          ex_alu_src_sel,
  output logic                          ex_DM_write,
  output logic                          ex_DM_en,
  output logic                          ex_branch,
  output logic                          ex_jump,
  output logic                          ex_en_pcplusimm,
  output logic                          ex_sel_src_pcplusimm,
  output logic                          ex_CSR_en,
  output logic [WORDTYPEWIDTH-1:0]      ex_memaccess_type,
  output logic                          ex_memaccess_sign,
  output logic [REGWRITENFROMWIDTH-1:0] ex_reg_write_sel,
  output logic                          dbg_state
);

  localparam logic [OPCODEWIDTH-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODEWIDTH-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODEWIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODEWIDTH-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODEWIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODEWIDTH-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODEWIDTH-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODEWIDTH-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODEWIDTH-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODEWIDTH-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic ALUSRCREG = 1'b0;
  localparam logic ALUSRCIMM = 1'b1;

  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMALU   = REGWRITENFROMWIDTH'(0);
  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMDM    = REGWRITENFROMWIDTH'(1);
  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMPC    = REGWRITENFROMWIDTH'(2);
  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMIMM   = REGWRITENFROMWIDTH'(3);
  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMPCIMM = REGWRITENFROMWIDTH'(4);
  localparam logic [REGWRITENFROMWIDTH-1:0] WBFROMCSR   = REGWRITENFROMWIDTH'(5);

  localparam logic [WORDTYPEWIDTH-1:0] MEMACCESSBYTE = WORDTYPEWIDTH'(1);
  localparam logic [WORDTYPEWIDTH-1:0] MEMACCESSHALF = WORDTYPEWIDTH'(3);
  localparam logic [WORDTYPEWIDTH-1:0] MEMACCESSWORD = WORDTYPEWIDTH'(15);
  localparam logic MEMACCESSSIGN   = 1'b0;
  localparam logic MEMACCESSUNSIGN = 1'b1;

  localparam int CW = (CSR_STALL_CYCLES < 2) ? 1 : $clog2(CSR_STALL_CYCLES + 1);

  typedef struct packed {
    logic                          rf_read;
    logic                          rf_write;
    logic                          alu_src_sel;
    logic                          dm_write;
    logic                          dm_en;
    logic                          branch;
    logic                          jump;
    logic                          en_pci;
    logic                          sel_pci;
    logic                          csr_en;
    logic [WORDTYPEWIDTH-1:0]      mtype;
    logic                          msign;
    logic [REGWRITENFROMWIDTH-1:0] wsel;
  } bundle_t;

  localparam bundle_t BUNDLE_DEFAULT = {10'b0, MEMACCESSWORD, MEMACCESSSIGN, WBFROMALU};

  typedef enum logic {RUN = 1'b0, CSR_WAIT = 1'b1} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_valid;
  logic                    r_illegal;
  logic [REGADDRWIDTH-1:0] r_rd;
  bundle_t                 r_bundle;

  bundle_t w_bundle;
  logic    w_illegal;
  logic    w_uses_rs2;
  logic    w_hazard;
  logic    w_advance;
  logic    w_accept;
  logic    w_is_system;

  always_comb begin
    w_bundle  = BUNDLE_DEFAULT;
    w_illegal = 1'b0;
    case (id_op)
      OP_R: begin
        w_bundle.rf_read = 1'b1; w_bundle.rf_write = 1'b1;
        w_bundle.alu_src_sel = ALUSRCREG; w_bundle.wsel = WBFROMALU;
      end
      OP_I: begin
        w_bundle.rf_read = 1'b1; w_bundle.rf_write = 1'b1;
        w_bundle.alu_src_sel = ALUSRCIMM; w_bundle.wsel = WBFROMALU;
      end
      OP_LOAD: begin
        w_bundle.rf_read = 1'b1; w_bundle.rf_write = 1'b1;
        w_bundle.alu_src_sel = ALUSRCIMM; w_bundle.dm_en = 1'b1; w_bundle.wsel = WBFROMDM;
        case (id_fun3)
          3'b000:  begin w_bundle.mtype = MEMACCESSBYTE; w_bundle.msign = MEMACCESSSIGN;   end
          3'b001:  begin w_bundle.mtype = MEMACCESSHALF; w_bundle.msign = MEMACCESSSIGN;   end
          3'b010:  begin w_bundle.mtype = MEMACCESSWORD; w_bundle.msign = MEMACCESSSIGN;   end
          3'b100:  begin w_bundle.mtype = MEMACCESSBYTE; w_bundle.msign = MEMACCESSUNSIGN; end
          3'b101:  begin w_bundle.mtype = MEMACCESSHALF; w_bundle.msign = MEMACCESSUNSIGN; end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_JALR: begin
        w_bundle.rf_read = 1'b1; w_bundle.rf_write = 1'b1; w_bundle.alu_src_sel = ALUSRCIMM;
        w_bundle.jump = 1'b1; w_bundle.en_pci = 1'b1; w_bundle.sel_pci = 1'b1;
        w_bundle.wsel = WBFROMPC;
      end
      OP_STORE: begin
        w_bundle.rf_read = 1'b1; w_bundle.alu_src_sel = ALUSRCIMM;
        w_bundle.dm_write = 1'b1; w_bundle.dm_en = 1'b1;
        case (id_fun3)
          3'b000:  w_bundle.mtype = MEMACCESSBYTE;
          3'b001:  w_bundle.mtype = MEMACCESSHALF;
          3'b010:  w_bundle.mtype = MEMACCESSWORD;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        w_bundle.rf_read = 1'b1; w_bundle.alu_src_sel = ALUSRCREG;
        w_bundle.branch = 1'b1; w_bundle.en_pci = 1'b1;
      end
      OP_LUI: begin
        w_bundle.rf_write = 1'b1; w_bundle.wsel = WBFROMIMM;
      end
      OP_AUIPC: begin
        w_bundle.rf_write = 1'b1; w_bundle.en_pci = 1'b1; w_bundle.wsel = WBFROMPCIMM;
      end
      OP_JAL: begin
        w_bundle.rf_write = 1'b1; w_bundle.jump = 1'b1; w_bundle.en_pci = 1'b1;
        w_bundle.wsel = WBFROMPC;
      end
      OP_SYSTEM: begin
        w_bundle.rf_read = 1'b1; w_bundle.rf_write = 1'b1; w_bundle.csr_en = 1'b1;
        w_bundle.wsel = WBFROMCSR;
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal encodings travel down the pipe as harmless no-ops carrying the flag.
    if (w_illegal) w_bundle = BUNDLE_DEFAULT;
  end

  assign w_is_system = (id_op == OP_SYSTEM);
  assign w_uses_rs2  = !w_illegal && (id_op == OP_R || id_op == OP_STORE || id_op == OP_BRANCH);

  assign w_hazard = r_valid && r_bundle.dm_en && !r_bundle.dm_write && (r_rd != '0) &&
                    ((w_bundle.rf_read && id_rs1 == r_rd) || (w_uses_rs2 && id_rs2 == r_rd));

  // Handshake: a transfer into EX happens when id_valid && id_ready; the EX register
  // advances when it is empty or EX takes it (ex_ready), otherwise every EX output holds.
  assign w_advance = ex_ready || !r_valid;
  assign id_ready  = (r_state == RUN) && !w_hazard && !flush && w_advance && rst_n;
  assign w_accept  = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_rd      <= '0;
      r_bundle  <= BUNDLE_DEFAULT;
      r_state   <= RUN;
      r_cnt     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      if (w_advance) begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_illegal <= w_illegal;
          r_rd      <= id_rd;
          r_bundle  <= w_bundle;
        end
      end
      case (r_state)
        RUN: if (w_accept && w_is_system) begin
          r_state <= CSR_WAIT;
          r_cnt   <= CW'(CSR_STALL_CYCLES);
        end
        CSR_WAIT: if (r_cnt <= CW'(1)) begin
          r_state <= RUN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign ex_valid             = r_valid;
  assign ex_rd                = r_rd;
  assign ex_illegal           = r_illegal;
  assign ex_rf_read           = r_bundle.rf_read;
  assign ex_rf_write          = r_bundle.rf_write;
  assign ex_alu_src_sel       = r_bundle.alu_src_sel;
  assign ex_DM_write          = r_bundle.dm_write;
  assign ex_DM_en             = r_bundle.dm_en;
  assign ex_branch            = r_bundle.branch;
  assign ex_jump              = r_bundle.jump;
  assign ex_en_pcplusimm      = r_bundle.en_pci;
  assign ex_sel_src_pcplusimm = r_bundle.sel_pci;
  assign ex_CSR_en            = r_bundle.csr_en;
  assign ex_memaccess_type    = r_bundle.mtype;
  assign ex_memaccess_sign    = r_bundle.msign;
  assign ex_reg_write_sel     = r_bundle.wsel;
  assign dbg_state            = (r_state == CSR_WAIT);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed, table-driven bench for decode_ctrl_pipe plus hand-written hazard,
// CSR-stall, flush, back-pressure and reset sequences.
module tb_decode_ctrl_pipe;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] BYTE = 4'd1, HALF = 4'd3, WORD = 4'd15;
  localparam logic S = 1'b0, U = 1'b1;
  localparam logic [2:0] ALU = 3'd0, DM = 3'd1, PC = 3'd2, IMM = 3'd3, PCIMM = 3'd4, CSR = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, flush, id_valid, ex_ready;
  logic       id_ready;
  logic [6:0] id_op;
  logic [2:0] id_fun3;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       ex_valid, ex_illegal;
  logic [4:0] ex_rd;
  logic       ex_rf_read, ex_rf_write, ex_alu_src_sel, ex_DM_write, ex_DM_en;
  logic       ex_branch, ex_jump, ex_en_pcplusimm, ex_sel_src_pcplusimm, ex_CSR_en;
  logic [3:0] ex_memaccess_type;
  logic       ex_memaccess_sign;
  logic [2:0] ex_reg_write_sel;
  logic       dbg_state;

  decode_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_fun3(id_fun3), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .ex_rf_read(ex_rf_read), .ex_rf_write(ex_rf_write), .ex_alu_src_sel(ex_alu_src_sel),
    .ex_DM_write(ex_DM_write), .ex_DM_en(ex_DM_en), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_en_pcplusimm(ex_en_pcplusimm), .ex_sel_src_pcplusimm(ex_sel_src_pcplusimm),
    .ex_CSR_en(ex_CSR_en), .ex_memaccess_type(ex_memaccess_type),
    .ex_memaccess_sign(ex_memaccess_sign), .ex_reg_write_sel(ex_reg_write_sel),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // {illegal, rf_read, rf_write, alu_src, DM_write, DM_en, branch, jump, en_pci, sel_pci, CSR_en, type, sign, wsel}
  logic [18:0] act_bundle;
  assign act_bundle = {ex_illegal, ex_rf_read, ex_rf_write, ex_alu_src_sel, ex_DM_write, ex_DM_en,
                       ex_branch, ex_jump, ex_en_pcplusimm, ex_sel_src_pcplusimm, ex_CSR_en,
                       ex_memaccess_type, ex_memaccess_sign, ex_reg_write_sel};

  function automatic logic [18:0] mkb(input logic [10:0] f, input logic [3:0] mt,
                                      input logic ms, input logic [2:0] ws);
    return {f, mt, ms, ws};
  endfunction

  localparam logic [18:0] RESET_BUNDLE = {11'b0, WORD, S, ALU};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  fun3;
    logic [4:0]  rd, rs1, rs2;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[20];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] s1, input logic [4:0] s2);
    id_valid = 1'b1; id_op = op; id_fun3 = f3; id_rd = rd; id_rs1 = s1; id_rs2 = s2;
  endtask

  task automatic load_use(input string tag, input logic [4:0] ld_rd, input logic [4:0] s1,
                          input logic [4:0] s2, input int exp_bubbles);
    int  bubbles;
    int  stalls;
    logic accepted;
    bubbles = 0; stalls = 0; accepted = 1'b0;
    @(negedge clk); drive(OP_LOAD, 3'b010, ld_rd, 5'd1, 5'd0);
    @(posedge clk); #1 drive(OP_R, 3'b000, 5'd6, s1, s2);
    for (int c = 0; c < 6 && !accepted; c++) begin
      @(negedge clk);
      if (!ex_valid) bubbles++;
      if (id_ready) accepted = 1'b1;
      else stalls++;
      @(posedge clk); #1;
      if (accepted) id_valid = 1'b0;
    end
    chk({tag, "_accepted"}, 32'(accepted), 32'd1);
    chk({tag, "_bubbles"}, 32'(bubbles), 32'(exp_bubbles));
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_bubbles));
    @(negedge clk);
    chk({tag, "_add_valid"}, 32'(ex_valid), 32'd1);
    chk({tag, "_add_rd"}, 32'(ex_rd), 32'd6);
    chk({tag, "_add_bundle"}, 32'(act_bundle), 32'(mkb(11'b0_1_1_0_0_0_0_0_0_0_0, WORD, S, ALU)));
    @(posedge clk);
  endtask

  initial begin
    vecs[0]  = '{"add",   OP_R,      3'b000, 5'd6,  5'd1, 5'd2, mkb(11'b0_1_1_0_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[1]  = '{"addi",  OP_I,      3'b000, 5'd7,  5'd1, 5'd2, mkb(11'b0_1_1_1_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[2]  = '{"lb",    OP_LOAD,   3'b000, 5'd8,  5'd1, 5'd2, mkb(11'b0_1_1_1_0_1_0_0_0_0_0, BYTE, S, DM)};
    vecs[3]  = '{"lh",    OP_LOAD,   3'b001, 5'd9,  5'd1, 5'd2, mkb(11'b0_1_1_1_0_1_0_0_0_0_0, HALF, S, DM)};
    vecs[4]  = '{"lw",    OP_LOAD,   3'b010, 5'd10, 5'd1, 5'd2, mkb(11'b0_1_1_1_0_1_0_0_0_0_0, WORD, S, DM)};
    vecs[5]  = '{"lbu",   OP_LOAD,   3'b100, 5'd11, 5'd1, 5'd2, mkb(11'b0_1_1_1_0_1_0_0_0_0_0, BYTE, U, DM)};
    vecs[6]  = '{"lhu",   OP_LOAD,   3'b101, 5'd12, 5'd1, 5'd2, mkb(11'b0_1_1_1_0_1_0_0_0_0_0, HALF, U, DM)};
    vecs[7]  = '{"jalr",  OP_JALR,   3'b000, 5'd13, 5'd1, 5'd2, mkb(11'b0_1_1_1_0_0_0_1_1_1_0, WORD, S, PC)};
    vecs[8]  = '{"sb",    OP_STORE,  3'b000, 5'd14, 5'd1, 5'd2, mkb(11'b0_1_0_1_1_1_0_0_0_0_0, BYTE, S, ALU)};
    vecs[9]  = '{"sh",    OP_STORE,  3'b001, 5'd15, 5'd1, 5'd2, mkb(11'b0_1_0_1_1_1_0_0_0_0_0, HALF, S, ALU)};
    vecs[10] = '{"sw",    OP_STORE,  3'b010, 5'd16, 5'd1, 5'd2, mkb(11'b0_1_0_1_1_1_0_0_0_0_0, WORD, S, ALU)};
    vecs[11] = '{"beq",   OP_BRANCH, 3'b000, 5'd17, 5'd1, 5'd2, mkb(11'b0_1_0_0_0_0_1_0_1_0_0, WORD, S, ALU)};
    vecs[12] = '{"lui",   OP_LUI,    3'b000, 5'd18, 5'd1, 5'd2, mkb(11'b0_0_1_0_0_0_0_0_0_0_0, WORD, S, IMM)};
    vecs[13] = '{"auipc", OP_AUIPC,  3'b000, 5'd19, 5'd1, 5'd2, mkb(11'b0_0_1_0_0_0_0_0_1_0_0, WORD, S, PCIMM)};
    vecs[14] = '{"jal",   OP_JAL,    3'b000, 5'd20, 5'd1, 5'd2, mkb(11'b0_0_1_0_0_0_0_1_1_0_0, WORD, S, PC)};
    vecs[15] = '{"op0",   7'b0000000, 3'b000, 5'd21, 5'd1, 5'd2, mkb(11'b1_0_0_0_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[16] = '{"st011", OP_STORE,  3'b011, 5'd22, 5'd1, 5'd2, mkb(11'b1_0_0_0_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[17] = '{"st111", OP_STORE,  3'b111, 5'd23, 5'd1, 5'd2, mkb(11'b1_0_0_0_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[18] = '{"ld011", OP_LOAD,   3'b011, 5'd24, 5'd1, 5'd2, mkb(11'b1_0_0_0_0_0_0_0_0_0_0, WORD, S, ALU)};
    vecs[19] = '{"ld110", OP_LOAD,   3'b110, 5'd25, 5'd1, 5'd2, mkb(11'b1_0_0_0_0_0_0_0_0_0_0, WORD, S, ALU)};

    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_op = '0; id_fun3 = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_rd", 32'(ex_rd), 32'd0);
    chk("reset_bundle", 32'(act_bundle), 32'(RESET_BUNDLE));
    chk("reset_id_ready", 32'(id_ready), 32'd1);
    chk("reset_state", 32'(dbg_state), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fun3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      chk({vecs[i].name, "_id_ready"}, 32'(id_ready), 32'd1);
      @(posedge clk); #1 id_valid = 1'b0;
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, 32'(ex_valid), 32'd1);
      chk({vecs[i].name, "_rd"}, 32'(ex_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_bundle"}, 32'(act_bundle), 32'(vecs[i].exp));
      @(posedge clk);
    end

    // LBU then LHU back to back.
    @(negedge clk); drive(OP_LOAD, 3'b100, 5'd3, 5'd1, 5'd2);
    @(posedge clk); #1 drive(OP_LOAD, 3'b101, 5'd4, 5'd1, 5'd2);
    @(negedge clk);
    chk("stream_lbu_valid", 32'(ex_valid), 32'd1);
    chk("stream_lbu_mem", 32'({ex_memaccess_type, ex_memaccess_sign}), 32'({BYTE, U}));
    chk("stream_id_ready", 32'(id_ready), 32'd1);
    @(posedge clk); #1 id_valid = 1'b0;
    @(negedge clk);
    chk("stream_lhu_valid", 32'(ex_valid), 32'd1);
    chk("stream_lhu_rd", 32'(ex_rd), 32'd4);
    chk("stream_lhu_mem", 32'({ex_memaccess_type, ex_memaccess_sign}), 32'({HALF, U}));
    @(posedge clk);

    load_use("lu_rs1", 5'd5, 5'd5, 5'd7, 1);
    load_use("lu_rs2", 5'd5, 5'd7, 5'd5, 1);
    load_use("lu_x0", 5'd0, 5'd0, 5'd7, 0);

    // csrrw: SYSTEM holds off issue for the programmed number of cycles.
    begin
      int  low;
      logic done;
      @(negedge clk); drive(OP_SYSTEM, 3'b001, 5'd1, 5'd2, 5'd0);
      chk("csr_id_ready", 32'(id_ready), 32'd1);
      @(posedge clk); #1 id_valid = 1'b0;
      @(negedge clk);
      chk("csr_valid", 32'(ex_valid), 32'd1);
      chk("csr_bundle", 32'(act_bundle), 32'(mkb(11'b0_1_1_0_0_0_0_0_0_0_1, WORD, S, CSR)));
      chk("csr_state", 32'(dbg_state), 32'd1);
      low = 0; done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        if (id_ready) done = 1'b1;
        else begin low++; @(negedge clk); end
      end
      chk("csr_stall_len", 32'(low), 32'd2);
      chk("csr_state_back", 32'(dbg_state), 32'd0);
    end

    // Flush in the first stall cycle ends the stall immediately.
    @(negedge clk); drive(OP_SYSTEM, 3'b001, 5'd1, 5'd2, 5'd0);
    @(posedge clk); #1 begin id_valid = 1'b0; flush = 1'b1; end
    @(negedge clk);
    chk("flush_cycle_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_id_ready_after", 32'(id_ready), 32'd1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_state", 32'(dbg_state), 32'd0);

    // Back-pressure: EX outputs hold while ex_ready is low, then reset clears everything.
    @(negedge clk); drive(OP_I, 3'b000, 5'd9, 5'd1, 5'd2);
    @(posedge clk); #1 begin ex_ready = 1'b0; drive(OP_LUI, 3'b000, 5'd12, 5'd0, 5'd0); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_id_ready", 32'(id_ready), 32'd0);
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_rd", 32'(ex_rd), 32'd9);
      chk("hold_bundle", 32'(act_bundle), 32'(mkb(11'b0_1_1_1_0_0_0_0_0_0_0, WORD, S, ALU)));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1 begin rst_n = 1'b1; id_valid = 1'b0; ex_ready = 1'b1; end
    @(negedge clk);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd0);
    chk("rst_bundle", 32'(act_bundle), 32'(RESET_BUNDLE));
    chk("rst_state", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
